// File: rtl/btb_pkg.sv
// Shared definitions for the associative branch target buffer: conditional-jump
// opcodes decoded in EX and the saturating-counter helpers used by every entry.
package btb_pkg;

  localparam logic [3:0] JUMPL  = 4'b0111;
  localparam logic [3:0] JUMPG  = 4'b1000;
  localparam logic [3:0] JUMPE  = 4'b1001;
  localparam logic [3:0] JUMPNE = 4'b1010;

  // Counters are carried in a 4-bit container; only the low ctr_w bits are meaningful.
  function automatic logic [3:0] sat_update(input logic [3:0] ctr, input logic up,
                                            input int unsigned ctr_w);
    logic [3:0] max_v;
    logic [3:0] res;
    max_v = 4'((5'd1 << ctr_w) - 5'd1);
    if (up) begin
      if (ctr == max_v) res = ctr;
      else              res = ctr + 4'd1;
    end else begin
      if (ctr == 4'd0)  res = ctr;
      else              res = ctr - 4'd1;
    end
    return res;
  endfunction

  function automatic logic [3:0] weak_taken(input int unsigned ctr_w);
    return 4'(5'd1 << (ctr_w - 1));
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup and EX-side training bundle of the branch target buffer.
interface btb_assoc_if #(
  parameter int PC_W = 16,
  parameter int WAYS = 4
) ();

  logic [PC_W-1:0] fetch_pc;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            flush;
  logic            btb_hit;
  logic            btb_prediction;
  logic [PC_W-1:0] btb_target;
  logic [WAYS-1:0] btb_hit_way;

  modport master (
    output fetch_pc, ex_valid, ex_pc, ex_taken, ex_target, flush,
    input  btb_hit, btb_prediction, btb_target, btb_hit_way
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_pc, ex_taken, ex_target, flush,
    output btb_hit, btb_prediction, btb_target, btb_hit_way
  );

endinterface

// File: rtl/btb_entry.sv
// One BTB way: valid/tag/target/counter storage plus its own lookup and EX compares.
module btb_entry
  import btb_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int CTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            alloc_en_i,
  input  logic            update_en_i,
  input  logic            taken_i,
  input  logic [PC_W-1:0] fetch_pc_i,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic [PC_W-1:0] ex_target_i,
  output logic            hit_o,
  output logic            ex_match_o,
  output logic            prediction_o,
  output logic            valid_o,
  output logic [PC_W-1:0] target_o
);

  logic             valid_q, valid_d;
  logic [PC_W-1:0]  tag_q, tag_d;
  logic [PC_W-1:0]  target_q, target_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;

  assign hit_o        = valid_q && (tag_q == fetch_pc_i);
  assign ex_match_o   = valid_q && (tag_q == ex_pc_i);
  assign prediction_o = ctr_q[CTR_W-1];
  assign valid_o      = valid_q;
  assign target_o     = target_q;

  // Next-state: flush beats allocation, allocation beats training.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (alloc_en_i) begin
      valid_d  = 1'b1;
      tag_d    = ex_pc_i;
      target_d = ex_target_i;
      ctr_d    = CTR_W'(weak_taken(CTR_W));
    end else if (update_en_i) begin
      ctr_d = CTR_W'(sat_update(4'(ctr_q), taken_i, CTR_W));
      if (taken_i) target_d = ex_target_i;
      else         target_d = target_q;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      tag_q    <= {PC_W{1'b0}};
      target_q <= {PC_W{1'b0}};
      ctr_q    <= {CTR_W{1'b0}};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Fully-associative BTB: per-way entries, lowest-index hit/victim priority,
// round-robin eviction pointer and the registered lookup outputs.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int WAYS  = 4,
  parameter int CTR_W = 2
) (
  input logic         clk,
  input logic         rst,
  btb_assoc_if.slave  bus
);

  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]  hit_s, ex_match_s, valid_s, pred_s;
  logic [WAYS-1:0]  hit_sel_s, upd_sel_s, inv_sel_s, victim_s;
  logic [WAYS-1:0]  alloc_en_s, update_en_s;
  logic [PC_W-1:0]  tgt_s [WAYS];
  logic             pred_mux_s, upd_ok_s, any_inv_s;
  logic [PC_W-1:0]  tgt_mux_s;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic             hit_q, pred_q;
  logic [PC_W-1:0]  tgt_q;
  logic [WAYS-1:0]  way_q;

  for (genvar g = 0; g < WAYS; g++) begin : g_entry
    btb_entry #(.PC_W(PC_W), .CTR_W(CTR_W)) u_entry (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (bus.flush),
      .alloc_en_i   (alloc_en_s[g]),
      .update_en_i  (update_en_s[g]),
      .taken_i      (bus.ex_taken),
      .fetch_pc_i   (bus.fetch_pc),
      .ex_pc_i      (bus.ex_pc),
      .ex_target_i  (bus.ex_target),
      .hit_o        (hit_s[g]),
      .ex_match_o   (ex_match_s[g]),
      .prediction_o (pred_s[g]),
      .valid_o      (valid_s[g]),
      .target_o     (tgt_s[g])
    );
  end

  // Lowest-set-bit isolation gives lowest-index priority for hits and the first free way.
  always_comb begin
    hit_sel_s  = hit_s & (~hit_s + WAYS'(1));
    upd_sel_s  = ex_match_s & (~ex_match_s + WAYS'(1));
    inv_sel_s  = ~valid_s & (valid_s + WAYS'(1));
    any_inv_s  = |inv_sel_s;
    pred_mux_s = 1'b0;
    tgt_mux_s  = {PC_W{1'b0}};
    for (int i = 0; i < WAYS; i++) begin
      pred_mux_s = pred_mux_s | (pred_s[i] & hit_sel_s[i]);
      tgt_mux_s  = tgt_mux_s | (tgt_s[i] & {PC_W{hit_sel_s[i]}});
    end
    upd_ok_s = bus.ex_valid & ~bus.flush;
    if (any_inv_s) victim_s = inv_sel_s;
    else           victim_s = WAYS'(1) << ptr_q;
    if (upd_ok_s) update_en_s = upd_sel_s;
    else          update_en_s = {WAYS{1'b0}};
    if (upd_ok_s && bus.ex_taken && !(|ex_match_s)) alloc_en_s = victim_s;
    else                                            alloc_en_s = {WAYS{1'b0}};
    // Pointer only moves when a valid way is actually evicted.
    if (bus.flush)                    ptr_d = {PTR_W{1'b0}};
    else if ((|alloc_en_s) && !any_inv_s) ptr_d = ptr_q + PTR_W'(1);
    else                              ptr_d = ptr_q;
  end

  // Round-robin pointer and registered lookup result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= {PTR_W{1'b0}};
      hit_q  <= 1'b0;
      pred_q <= 1'b0;
      tgt_q  <= {PC_W{1'b0}};
      way_q  <= {WAYS{1'b0}};
    end else if (bus.flush) begin
      ptr_q  <= ptr_d;
      hit_q  <= 1'b0;
      pred_q <= 1'b0;
      tgt_q  <= {PC_W{1'b0}};
      way_q  <= {WAYS{1'b0}};
    end else begin
      ptr_q  <= ptr_d;
      hit_q  <= |hit_s;
      pred_q <= pred_mux_s;
      tgt_q  <= tgt_mux_s;
      way_q  <= hit_sel_s;
    end
  end

  assign bus.btb_hit        = hit_q;
  assign bus.btb_prediction = pred_q;
  assign bus.btb_target     = tgt_q;
  assign bus.btb_hit_way    = way_q;

endmodule
